multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit accumulator CPU datapath.
- Sequences fetch, decode, execute, memory and writeback over a shared single-port memory using a req/ready handshake.
- Decodes instr[15:11] as the opcode and drives the 11-bit immediate extender select (sign or zero), ALU op, PC, IR and accumulator write enables.

Parameters:
- OPW, 5, opcode width; instruction = OPW opcode bits + (16-OPW) immediate bits.
- ALUW, 3, width of alu_op.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  16  current instruction register contents.
- acc_zero  in  1  accumulator == 0 flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write request; valid while mem_req.
- addr_sel  out  1  0 = PC drives the address, 1 = ALU result drives it.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC from pc_src.
- pc_src  out  1  0 = PC+1, 1 = PC + sext(imm11).
- imm_sign  out  1  1 = sign-extend imm11 to 16 bits, 0 = zero-extend.
- alu_op  out  ALUW  0 = pass B, 1 = add, 2 = and, 3 = or.
- acc_write  out  1  load the accumulator.
- acc_src  out  1  0 = ALU, 1 = memory data.
- halted  out  1  core is stopped.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free. Outputs are registered-state Moore, except that ir_write and the memory-stage enables qualify on mem_ready.
- Reset (async, rst_n = 0):
  - State goes to FETCH.
  - All outputs are 0.
  - Release is synchronised; the first FETCH cycle is the first clk edge with rst_n = 1.
- FETCH:
  - mem_req = 1, mem_we = 0, addr_sel = 0.
  - Stays in FETCH while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE: one cycle, no enables asserted. Next state is EXEC, except HALT opcode goes to HALT.
- Opcodes:
  - 00 NOP
  - 01 ADDI: acc += sext(imm)
  - 02 ANDI: acc &= zext(imm)
  - 03 ORI: acc |= zext(imm)
  - 04 LD: acc = mem[sext(imm)]
  - 05 ST: mem[sext(imm)] = acc
  - 06 BEQZ: if acc_zero, PC += sext(imm)
  - 07 JMP: PC += sext(imm)
  - 1F HALT
  - All other codes are illegal.
- EXEC:
  - ADDI/ANDI/ORI: set alu_op and imm_sign (1 for ADDI, 0 otherwise), then go to WB.
  - LD/ST: alu_op = 0, imm_sign = 1, then go to MEM.
  - BEQZ: pc_write = acc_zero, pc_src = 1, imm_sign = 1, then go to FETCH.
  - JMP: same as BEQZ but pc_write = 1.
  - NOP: go to FETCH.
  - Illegal: illegal = 1 for one cycle; handling per the optional feature.
- Branch PC arithmetic: the offset is relative to the already-incremented PC and wraps modulo 2^16.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = 1 for ST.
  - Held in MEM with all request outputs stable while mem_ready = 0.
  - On mem_ready: ST goes to FETCH; LD asserts acc_write = 1, acc_src = 1 and goes to FETCH.
- WB: acc_write = 1, acc_src = 0, alu_op and imm_sign held from EXEC, then go to FETCH.
- HALT:
  - halted = 1, all other enables 0.
  - Left only by reset.
- Latencies with zero wait states:
  - ALU ops: 4 cycles.
  - LD/ST: 4 cycles.
  - Branch/NOP: 3 cycles.
- Each wait cycle adds one cycle.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-request drops mem_req asynchronously. No write is committed by this block; the memory must ignore a request withdrawn without ready.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal opcode pulses illegal, then goes to HALT on the next edge.
- Undefined: an illegal opcode pulses illegal and executes as NOP (returns to FETCH).

Test Plan:
- Reset/ADDI:
  - Stimulus: hold rst_n = 0, release, mem_ready = 1, ir = 0x0FFF (ADDI imm = 0x7FF).
  - Required: all outputs 0 under reset; FETCH → DECODE → EXEC → WB in 4 cycles; imm_sign = 1, alu_op = 1, acc_write pulse in WB.
- ADDI with negative immediate:
  - Stimulus: ir = 0x0C00.
  - Required: imm_sign = 1, so the datapath sees 0xFC00.
- ORI:
  - Stimulus: ir = 0x1C00.
  - Required: imm_sign = 0.
- Wait states:
  - Stimulus: LD ir = 0x2005 with mem_ready held low for 3 cycles in both FETCH and MEM.
  - Required: mem_req and addr_sel stable throughout; acc_write = 1, acc_src = 1 exactly on the ready cycle; total 10 cycles.
- Branch:
  - Stimulus: BEQZ ir = 0x37FE with acc_zero = 1, then with acc_zero = 0.
  - Required: pc_write = 1, pc_src = 1 in EXEC for the first; pc_write = 0 for the second; both return to FETCH.
- Illegal opcode:
  - Stimulus: ir = 0x4000 (opcode 08).
  - Required: illegal pulses 1 cycle. With ILLEGAL_TRAP_EN: halted = 1 thereafter, mem_req stays 0. Without: next FETCH issues mem_req.
- HALT and reset mid-request:
  - Stimulus: ir = 0xF800; then assert rst_n = 0 during a FETCH wait.
  - Required: halted = 1 persists with mem_ready toggling; mem_req falls immediately on reset, before the next edge.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the accumulator datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
   parameter int ALUW = 3
);
   logic [15:0]     ir;
   logic            acc_zero;
   logic            mem_ready;
   logic            mem_req;
   logic            mem_we;
   logic            addr_sel;
   logic            ir_write;
   logic            pc_write;
   logic            pc_src;
   logic            imm_sign;
   logic [ALUW-1:0] alu_op;
   logic            acc_write;
   logic            acc_src;
   logic            halted;
   logic            illegal;

   // mem_req is held with mem_we/addr_sel stable until the cycle mem_ready is high;
   // that cycle completes the transfer.
   modport master (
      input  ir, acc_zero, mem_ready,
      output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sign,
             alu_op, acc_write, acc_src, halted, illegal
   );

   modport slave (
      output ir, acc_zero, mem_ready,
      input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sign,
             alu_op, acc_write, acc_src, halted, illegal
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit accumulator CPU.
// Define ILLEGAL_TRAP_EN to halt on an undefined opcode; otherwise it executes as NOP.
module multicycle_ctrl #(
   parameter int OPW  = 5,
   parameter int ALUW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master bus,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
   localparam logic [OPW-1:0] OP_ANDI = OPW'(2);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(3);
   localparam logic [OPW-1:0] OP_LD   = OPW'(4);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5);
   localparam logic [OPW-1:0] OP_BEQZ = OPW'(6);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(7);
   localparam logic [OPW-1:0] OP_HALT = OPW'(31);

   state_e          state_q, state_d;
   logic            active_q;
   logic [OPW-1:0]  opcode;
   logic [ALUW-1:0] alu_sel;
   logic            unused_imm;

   assign opcode      = bus.ir[15 -: OPW];
   assign unused_imm  = ^bus.ir[15-OPW:0];
   assign dbg_state_o = state_q;

   // active_q synchronises reset release: outputs stay 0 until the first edge
   // with rst_n high, and drop asynchronously the moment rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         active_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
         if (active_q) state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.addr_sel  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_src    = 1'b0;
      bus.imm_sign  = 1'b0;
      bus.alu_op    = '0;
      bus.acc_write = 1'b0;
      bus.acc_src   = 1'b0;
      bus.halted    = 1'b0;
      bus.illegal   = 1'b0;

      alu_sel = '0;
      case (opcode)
         OP_ADDI: alu_sel = ALUW'(1);
         OP_ANDI: alu_sel = ALUW'(2);
         OP_ORI:  alu_sel = ALUW'(3);
         default: alu_sel = '0;
      endcase

      if (active_q) begin
         case (state_q)
            S_FETCH: begin
               bus.mem_req = 1'b1;
               if (bus.mem_ready) begin
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = S_DECODE;
               end
            end
            S_DECODE: state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
               case (opcode)
                  OP_ADDI, OP_ANDI, OP_ORI: begin
                     bus.alu_op   = alu_sel;
                     bus.imm_sign = (opcode == OP_ADDI);
                     state_d      = S_WB;
                  end
                  OP_LD, OP_ST: begin
                     bus.imm_sign = 1'b1;
                     state_d      = S_MEM;
                  end
                  OP_BEQZ, OP_JMP: begin
                     bus.pc_write = (opcode == OP_JMP) | bus.acc_zero;
                     bus.pc_src   = 1'b1;
                     bus.imm_sign = 1'b1;
                     state_d      = S_FETCH;
                  end
                  OP_NOP:  state_d = S_FETCH;
                  OP_HALT: state_d = S_HALT;
                  default: begin
                     bus.illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                     state_d     = S_HALT;
`else
                     state_d     = S_FETCH;
`endif
                  end
               endcase
            end
            // Address = pass-B of sext(imm); held stable for the whole wait.
            S_MEM: begin
               bus.mem_req  = 1'b1;
               bus.addr_sel = 1'b1;
               bus.mem_we   = (opcode == OP_ST);
               bus.imm_sign = 1'b1;
               if (bus.mem_ready) begin
                  bus.acc_write = (opcode == OP_LD);
                  bus.acc_src   = (opcode == OP_LD);
                  state_d       = S_FETCH;
               end
            end
            S_WB: begin
               bus.alu_op    = alu_sel;
               bus.imm_sign  = (opcode == OP_ADDI);
               bus.acc_write = 1'b1;
               state_d       = S_FETCH;
            end
            S_HALT:  bus.halted = 1'b1;
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control-vector checks
// for ALU ops, LD/ST with wait states, branches, illegal opcode, HALT and reset.
module tb_multicycle_ctrl;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   // ctrl = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sign,
   //         alu_op[2:0], acc_write, acc_src, halted, illegal}
   localparam logic [13:0] B_REQ  = 14'h2000;
   localparam logic [13:0] B_WE   = 14'h1000;
   localparam logic [13:0] B_ASEL = 14'h0800;
   localparam logic [13:0] B_IRW  = 14'h0400;
   localparam logic [13:0] B_PCW  = 14'h0200;
   localparam logic [13:0] B_PCS  = 14'h0100;
   localparam logic [13:0] B_SGN  = 14'h0080;
   localparam logic [13:0] A_ADD  = 14'h0010;
   localparam logic [13:0] A_AND  = 14'h0020;
   localparam logic [13:0] A_OR   = 14'h0030;
   localparam logic [13:0] B_ACCW = 14'h0008;
   localparam logic [13:0] B_ACCS = 14'h0004;
   localparam logic [13:0] B_HLT  = 14'h0002;
   localparam logic [13:0] B_ILL  = 14'h0001;
   localparam logic [13:0] F_RDY  = B_REQ | B_IRW | B_PCW;
   localparam logic [13:0] NONE   = 14'h0000;

   logic        clk;
   logic        rst_n;
   logic [2:0]  dbg_state;
   logic [13:0] ctrl;
   int          checks;
   int          passed;

   multicycle_ctrl_if #(.ALUW(3)) bus ();

   multicycle_ctrl #(.OPW(5), .ALUW(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.master),
      .dbg_state_o (dbg_state)
   );

   assign ctrl = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write,
                  bus.pc_src, bus.imm_sign, bus.alu_op, bus.acc_write, bus.acc_src,
                  bus.halted, bus.illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic run_cycle(input logic rdy);
      @(negedge clk);
      bus.mem_ready = rdy;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; bus.mem_ready = 1'b0; bus.ir = 16'h0FFF; bus.acc_zero = 1'b0;
      run_cycle(1'b0);
      checks++;
      if ({dbg_state, ctrl} !== {S_FETCH, NONE})
         $display("FAIL reset_hold: got %h want %h", {dbg_state, ctrl}, {S_FETCH, NONE});
      else passed++;
      run_cycle(1'b1);
      checks++;
      if ({dbg_state, ctrl} !== {S_FETCH, NONE})
         $display("FAIL reset_ready_ignored: got %h want %h", {dbg_state, ctrl}, {S_FETCH, NONE});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({dbg_state, ctrl} !== {S_FETCH, NONE})
         $display("FAIL reset_release: got %h want %h", {dbg_state, ctrl}, {S_FETCH, NONE});
      else passed++;
   endtask

   task automatic test_alu(input logic [15:0] instr, input logic [13:0] ex, input string name);
      logic [16:0] want [4];
      want = '{{S_FETCH, F_RDY}, {S_DECODE, NONE}, {S_EXEC, ex}, {S_WB, ex | B_ACCW}};
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1);
         checks++;
         if ({dbg_state, ctrl} !== want[i])
            $display("FAIL %s cyc %0d: got %h want %h", name, i, {dbg_state, ctrl}, want[i]);
         else passed++;
         if (i == 0) bus.ir = instr;
      end
   endtask

   task automatic test_ld_wait;
      logic [16:0] want [10];
      logic        rdy  [10];
      rdy  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      want = '{{S_FETCH, B_REQ}, {S_FETCH, B_REQ}, {S_FETCH, B_REQ}, {S_FETCH, F_RDY},
               {S_DECODE, NONE}, {S_EXEC, B_SGN},
               {S_MEM, B_REQ | B_ASEL | B_SGN}, {S_MEM, B_REQ | B_ASEL | B_SGN},
               {S_MEM, B_REQ | B_ASEL | B_SGN},
               {S_MEM, B_REQ | B_ASEL | B_SGN | B_ACCW | B_ACCS}};
      for (int i = 0; i < 10; i++) begin
         run_cycle(rdy[i]);
         checks++;
         if ({dbg_state, ctrl} !== want[i])
            $display("FAIL ld_wait cyc %0d: got %h want %h", i, {dbg_state, ctrl}, want[i]);
         else passed++;
         if (i == 3) bus.ir = 16'h2005;
      end
   endtask

   task automatic test_st;
      logic [16:0] want [4];
      want = '{{S_FETCH, F_RDY}, {S_DECODE, NONE}, {S_EXEC, B_SGN},
               {S_MEM, B_REQ | B_WE | B_ASEL | B_SGN}};
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1);
         checks++;
         if ({dbg_state, ctrl} !== want[i])
            $display("FAIL st cyc %0d: got %h want %h", i, {dbg_state, ctrl}, want[i]);
         else passed++;
         if (i == 0) bus.ir = 16'h2805;
      end
   endtask

   task automatic test_branch(input logic [15:0] instr, input logic az,
                              input logic [13:0] ex, input string name);
      logic [16:0] want [3];
      bus.acc_zero = az;
      want = '{{S_FETCH, F_RDY}, {S_DECODE, NONE}, {S_EXEC, ex}};
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b1);
         checks++;
         if ({dbg_state, ctrl} !== want[i])
            $display("FAIL %s cyc %0d: got %h want %h", name, i, {dbg_state, ctrl}, want[i]);
         else passed++;
         if (i == 0) bus.ir = instr;
      end
   endtask

   task automatic test_illegal;
      logic [16:0] want [5];
      logic        rdy  [5];
`ifdef ILLEGAL_TRAP_EN
      rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      want = '{{S_FETCH, F_RDY}, {S_DECODE, NONE}, {S_EXEC, B_ILL},
               {S_HALT, B_HLT}, {S_HALT, B_HLT}};
`else
      rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      want = '{{S_FETCH, F_RDY}, {S_DECODE, NONE}, {S_EXEC, B_ILL},
               {S_FETCH, B_REQ}, {S_FETCH, F_RDY}};
`endif
      for (int i = 0; i < 5; i++) begin
         run_cycle(rdy[i]);
         checks++;
         if ({dbg_state, ctrl} !== want[i])
            $display("FAIL illegal cyc %0d: got %h want %h", i, {dbg_state, ctrl}, want[i]);
         else passed++;
         if (i == 0) bus.ir = 16'h4000;
      end
`ifdef ILLEGAL_TRAP_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.ir = 16'h0000;
      test_branch(16'h0000, 1'b0, NONE, "nop_after_trap");
`else
      bus.ir = 16'h0000;
      run_cycle(1'b1);
      run_cycle(1'b1);
`endif
   endtask

   task automatic test_halt_reset;
      logic [16:0] want [6];
      logic        rdy  [6];
      rdy  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      want = '{{S_FETCH, F_RDY}, {S_DECODE, NONE}, {S_HALT, B_HLT},
               {S_HALT, B_HLT}, {S_HALT, B_HLT}, {S_HALT, B_HLT}};
      for (int i = 0; i < 6; i++) begin
         run_cycle(rdy[i]);
         checks++;
         if ({dbg_state, ctrl} !== want[i])
            $display("FAIL halt cyc %0d: got %h want %h", i, {dbg_state, ctrl}, want[i]);
         else passed++;
         if (i == 0) bus.ir = 16'hF800;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(1'b0);
      checks++;
      if ({dbg_state, ctrl} !== {S_FETCH, B_REQ})
         $display("FAIL fetch_wait_after_reset: got %h want %h", {dbg_state, ctrl}, {S_FETCH, B_REQ});
      else passed++;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dbg_state, ctrl} !== {S_FETCH, NONE})
         $display("FAIL reset_mid_req: got %h want %h", {dbg_state, ctrl}, {S_FETCH, NONE});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(1'b1);
      checks++;
      if ({dbg_state, ctrl} !== {S_FETCH, F_RDY})
         $display("FAIL fetch_after_mid_reset: got %h want %h", {dbg_state, ctrl}, {S_FETCH, F_RDY});
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_alu(16'h0FFF, B_SGN | A_ADD, "addi_pos");
      test_alu(16'h0C00, B_SGN | A_ADD, "addi_neg");
      test_alu(16'h1C00, A_OR, "ori");
      test_alu(16'h1000, A_AND, "andi");
      test_ld_wait();
      test_st();
      test_branch(16'h37FE, 1'b1, B_PCW | B_PCS | B_SGN, "beqz_taken");
      test_branch(16'h37FE, 1'b0, B_PCS | B_SGN, "beqz_not_taken");
      test_branch(16'h3800, 1'b0, B_PCW | B_PCS | B_SGN, "jmp");
      test_branch(16'h0000, 1'b0, NONE, "nop");
      test_illegal();
      test_halt_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
